// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset vector, NOP encoding,
// RV32 major opcodes and the fetch-stage state type.
package cpu_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    typedef enum logic [1:0] {
        RST_IDLE,
        FETCH,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: request/address out, same-cycle ready/data back.
interface if_stage_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage_instr_fields.sv
// Combinational split of the held instruction into the fields used by control.
module instr_fields #(
    parameter int OPLEN = 7
) (
    input  logic [31:0]      instr,
    output logic [OPLEN-1:0] op,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2
);
    assign op     = instr[OPLEN-1:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding fetch, single-entry hold register
// towards decode, redirect handling with drop of in-flight responses.
module if_stage #(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC),
    parameter int              OPLEN    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    if_stage_if.master       imem,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [31:0]      id_instr,
    output logic [XLEN-1:0]  id_pc,
    output logic [OPLEN-1:0] op,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2
);
    import cpu_pkg::*;

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] pend_pc, pend_pc_n;
    logic            discard, discard_n;
    logic            id_valid_n;
    logic [31:0]     id_instr_n;
    logic [XLEN-1:0] id_pc_n;
    logic [XLEN-1:0] redirect_tgt;
    logic            unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // pc only moves on response or in HOLD, so the address stays put while a request waits
    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST_IDLE;
            pc       <= RESET_PC;
            pend_pc  <= RESET_PC;
            discard  <= 1'b0;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= RESET_PC;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            pend_pc  <= pend_pc_n;
            discard  <= discard_n;
            id_valid <= id_valid_n;
            id_instr <= id_instr_n;
            id_pc    <= id_pc_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        pend_pc_n  = pend_pc;
        discard_n  = discard;
        id_valid_n = id_valid;
        id_instr_n = id_instr;
        id_pc_n    = id_pc;
        case (state)
            RST_IDLE: begin
                state_n = FETCH;
                pc_n    = RESET_PC;
            end
            FETCH: begin
                if (imem.imem_ready) begin
                    if (discard || redirect) begin
                        // a redirect arriving with the response supersedes any older pending target
                        pc_n      = redirect ? redirect_tgt : pend_pc;
                        discard_n = 1'b0;
                    end else begin
                        id_instr_n = imem.imem_rdata;
                        id_pc_n    = pc;
                        id_valid_n = 1'b1;
                        pc_n       = pc + XLEN'(4);
                        state_n    = HOLD;
                    end
                end else if (redirect) begin
                    pend_pc_n = redirect_tgt;
                    discard_n = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    id_valid_n = 1'b0;
                    pc_n       = redirect_tgt;
                    state_n    = FETCH;
                end else if (id_ready) begin
                    id_valid_n = 1'b0;
                    state_n    = FETCH;
                end
            end
            default: state_n = RST_IDLE;
        endcase
    end

    instr_fields #(
        .OPLEN(OPLEN)
    ) u_fields (
        .instr (id_instr),
        .op    (op),
        .funct3(funct3),
        .funct7(funct7),
        .rd    (rd),
        .rs1   (rs1),
        .rs2   (rs2)
    );
endmodule
